vga_pixel_pipe: RTL and testbench

- Downstream stage of the VGA area tracker. Consumes the tracker's coordinates, visible flag and raw syncs; produces registered RGB and matching delayed syncs for the board pins.
- Replaces the free-running time counter with a frame counter that advances on each vertical sync start.
- Supports frame-synchronous pattern selection.
- The whole path is pipelined: RGB and syncs leave the block aligned, with fixed latency.

---
 rtl/vga_pixel_pipe.sv | 162 ++++++++++++++++
 tb/tb_vga_pixel_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: output stage behind the VGA area tracker.
// Registers the tracker's coordinates and syncs, then generates RGB
// alongside syncs delayed by the same two cycles.
// A frame counter advances on each vertical sync leading edge.
// The pattern mode is taken from i_mode only at frame start.
// Optional: define VGA_PIXEL_PIPE_COLOR_BARS_EN to turn mode 3 into colour bars.
// Without that macro, mode 3 falls back to the XOR pattern.
module vga_pixel_pipe #(
    parameter int CNT_WIDTH   = 10,
    parameter int COLOR_WIDTH = 3,
    parameter int SYNC_ACTIVE = 0,
    parameter int FRAME_SHIFT = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [CNT_WIDTH-1:0]   i_h_coord,
    input  logic [CNT_WIDTH-1:0]   i_v_coord,
    input  logic                   i_visible,
    input  logic                   i_h_sync,
    input  logic                   i_v_sync,
    input  logic [1:0]             i_mode,
    output logic [COLOR_WIDTH-1:0] o_r,
    output logic [COLOR_WIDTH-1:0] o_g,
    output logic [COLOR_WIDTH-1:0] o_b,
    output logic                   o_h_sync,
    output logic                   o_v_sync,
    output logic [15:0]            o_frame,
    output logic                   o_frame_start
);

    localparam int   P        = 3 * COLOR_WIDTH;
    localparam logic SYNC_ON  = (SYNC_ACTIVE != 0);
    localparam logic SYNC_OFF = (SYNC_ACTIVE == 0);

    typedef enum logic [1:0] {
        MODE_XOR     = 2'd0,
        MODE_WHITE   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_BARS    = 2'd3
    } mode_e;

    // Stage 1
    logic [CNT_WIDTH-1:0] x_s1;
    logic [CNT_WIDTH-1:0] y_s1;
    logic                 vis_s1;
    logic                 hs_s1;
    logic                 vs_s1;

    // Frame-edge detector and frame state
    logic                 det_vs;
    logic                 det_vs_prev;
    logic                 frame_start_s1;
    logic [15:0]          frame_cnt;
    mode_e                mode_q;

    // Pattern generation and stage 2
    logic [P-1:0]         xor_pix;
    logic [P-1:0]         pix_next;
    logic [P-1:0]         rgb_s2;
    logic                 hs_s2;
    logic                 vs_s2;
    logic                 fs_s2;

`ifdef VGA_PIXEL_PIPE_COLOR_BARS_EN
    logic [2:0]           bar_idx;
    logic [P-1:0]         bar_pix;
`endif

    // Stage 1: capture the tracker outputs; syncs clear to their inactive level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x_s1   <= '0;
            y_s1   <= '0;
            vis_s1 <= 1'b0;
            hs_s1  <= SYNC_OFF;
            vs_s1  <= SYNC_OFF;
        end else begin
            // NOTE: non-blocking assignments let every register sample pre-edge values, so stage order never matters.
            x_s1   <= i_h_coord;
            y_s1   <= i_v_coord;
            vis_s1 <= i_visible;
            hs_s1  <= i_h_sync;
            vs_s1  <= i_v_sync;
        end
    end

    // Edge detector: a private copy of stage-1 vsync plus its previous value.
    // Both reset to the active level, so a reset released inside the pulse is not counted.
    // The visible vs_s1 still clears inactive, so o_v_sync never glitches after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            det_vs      <= SYNC_ON;
            det_vs_prev <= SYNC_ON;
        end else begin
            det_vs      <= i_v_sync;
            det_vs_prev <= det_vs;
        end
    end

    assign frame_start_s1 = (det_vs == SYNC_ON) && (det_vs_prev != SYNC_ON);

    // Frame counter and active mode change only at frame start, never mid-line.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            frame_cnt <= '0;
            mode_q    <= MODE_XOR;
        end else if (frame_start_s1) begin
            frame_cnt <= frame_cnt + 16'd1;
            mode_q    <= mode_e'(i_mode);
        end
    end

`ifdef VGA_PIXEL_PIPE_COLOR_BARS_EN
    // Colour bars: the top three x bits pick one of eight bars.
    assign bar_idx = x_s1[CNT_WIDTH-1 -: 3];
    assign bar_pix = {{COLOR_WIDTH{bar_idx[2]}}, {COLOR_WIDTH{bar_idx[1]}}, {COLOR_WIDTH{bar_idx[0]}}};
`endif

    // XOR pattern scrolls with the scaled frame count; the width cast wraps it modulo 2^P.
    assign xor_pix = P'(x_s1 ^ y_s1) + P'(frame_cnt >> FRAME_SHIFT);

    // Pattern select and blanking for the pixel now in stage 1.
    always_comb begin
        // NOTE: a default before the case means every path assigns pix_next, so no latch is inferred.
        pix_next = xor_pix;
        case (mode_q)
            MODE_WHITE:   pix_next = '1;
            MODE_CHECKER: pix_next = (x_s1[5] ^ y_s1[5]) ? '1 : '0;
`ifdef VGA_PIXEL_PIPE_COLOR_BARS_EN
            MODE_BARS:    pix_next = bar_pix;
`endif
            default:      pix_next = xor_pix;
        endcase
        if (!vis_s1) begin
            pix_next = '0;
        end
    end

    // Stage 2: RGB, syncs and frame-start pulse leave together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rgb_s2 <= '0;
            hs_s2  <= SYNC_OFF;
            vs_s2  <= SYNC_OFF;
            fs_s2  <= 1'b0;
        end else begin
            rgb_s2 <= pix_next;
            hs_s2  <= hs_s1;
            vs_s2  <= vs_s1;
            fs_s2  <= frame_start_s1;
        end
    end

    assign o_r           = rgb_s2[P-1 -: COLOR_WIDTH];
    assign o_g           = rgb_s2[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
    assign o_b           = rgb_s2[COLOR_WIDTH-1:0];
    assign o_h_sync      = hs_s2;
    assign o_v_sync      = vs_s2;
    assign o_frame       = frame_cnt;
    assign o_frame_start = fs_s2;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb_vga_pixel_pipe: directed and random stimulus for vga_pixel_pipe.
// Default parameters are used: 10-bit coordinates, 3 bits per channel,
// active-low syncs, and the frame count shifted right by 2.
// The reference model works from behaviour, not from the RTL structure:
// - each pixel appears two clocks after it is applied;
// - a new frame starts when the delayed vsync goes active;
// - the pattern is computed with plain integer arithmetic.
module tb_vga_pixel_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] h_coord;
    logic [9:0] v_coord;
    logic       visible;
    logic       h_sync;
    logic       v_sync;
    logic [1:0] mode;
    logic [2:0] o_r;
    logic [2:0] o_g;
    logic [2:0] o_b;
    logic       o_h_sync;
    logic       o_v_sync;
    logic [15:0] o_frame;
    logic       o_frame_start;

    int n_vec = 0;
    int n_err = 0;

    // Model state: last applied pixel, last two applied vsync levels, frame/mode.
    typedef struct {
        int x;
        int y;
        bit vis;
        bit hs;
        bit vs;
    } pix_t;

    pix_t seen;
    bit   vs_now;
    bit   vs_prev;
    int   m_frame;
    int   m_mode;
    int   e_rgb;
    bit   e_hs;
    bit   e_vs;
    bit   e_fs;
    int   e_frame;
    int   fs_count;

    always #5 clk = ~clk;

    vga_pixel_pipe dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_h_coord     (h_coord),
        .i_v_coord     (v_coord),
        .i_visible     (visible),
        .i_h_sync      (h_sync),
        .i_v_sync      (v_sync),
        .i_mode        (mode),
        .o_r           (o_r),
        .o_g           (o_g),
        .o_b           (o_b),
        .o_h_sync      (o_h_sync),
        .o_v_sync      (o_v_sync),
        .o_frame       (o_frame),
        .o_frame_start (o_frame_start)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Expected 9-bit {r,g,b} for one pixel under a given mode and frame count.
    function automatic int expected_pixel(input pix_t p, input int md, input int frame);
        int c;
        if (!p.vis) return 0;
        case (md)
            1: return 511;
            2: return (((p.x / 32) % 2) != ((p.y / 32) % 2)) ? 511 : 0;
`ifdef VGA_PIXEL_PIPE_COLOR_BARS_EN
            3: begin
                c = p.x / 128;
                return (((c / 4) % 2) * 7) * 64 + (((c / 2) % 2) * 7) * 8 + (c % 2) * 7;
            end
`endif
            default: return ((p.x ^ p.y) + frame / 4) % 512;
        endcase
    endfunction

    task automatic model_reset();
        seen    = '{x: 0, y: 0, vis: 1'b0, hs: 1'b1, vs: 1'b1};
        vs_now  = 1'b0;
        vs_prev = 1'b0;
        m_frame = 0;
        m_mode  = 0;
        e_rgb   = 0;
        e_hs    = 1'b1;
        e_vs    = 1'b1;
        e_fs    = 1'b0;
        e_frame = 0;
    endtask

    // One clock edge of behaviour, using the inputs applied at that edge.
    task automatic model_edge();
        bit fs;
        fs      = (vs_now == 1'b0) && (vs_prev == 1'b1);
        e_rgb   = expected_pixel(seen, m_mode, m_frame);
        e_hs    = seen.hs;
        e_vs    = seen.vs;
        e_fs    = fs;
        if (fs) begin
            m_frame = (m_frame + 1) % 65536;
            m_mode  = int'(mode);
        end
        e_frame = m_frame;
        vs_prev = vs_now;
        vs_now  = v_sync;
        seen    = '{x: int'(h_coord), y: int'(v_coord), vis: visible, hs: h_sync, vs: v_sync};
    endtask

    task automatic check_outputs();
        check("rgb", 32'({o_r, o_g, o_b}), 32'(e_rgb));
        check("h_sync", 32'(o_h_sync), 32'(e_hs));
        check("v_sync", 32'(o_v_sync), 32'(e_vs));
        check("frame_start", 32'(o_frame_start), 32'(e_fs));
        check("frame", 32'(o_frame), 32'(e_frame));
    endtask

    // Apply one pixel, clock it, advance the model and compare 1 ns after the edge.
    task automatic step(input int x, input int y, input bit vis, input bit hs, input bit vs);
        h_coord = 10'(x);
        v_coord = 10'(y);
        visible = vis;
        h_sync  = hs;
        v_sync  = vs;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check_outputs();
        if (o_frame_start) fs_count++;
    endtask

    // Blanked vertical sync pulse: inactive, active for low_cycles, inactive.
    task automatic vsync_pulse(input int low_cycles);
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < low_cycles; i++) step(0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        rst     = 1'b1;
        h_coord = '0;
        v_coord = '0;
        visible = 1'b0;
        h_sync  = 1'b1;
        v_sync  = 1'b1;
        mode    = 2'd0;
        fs_count = 0;
        model_reset();

        // Reset state
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b1, 1'b1);
        check("reset_rgb", 32'({o_r, o_g, o_b}), 32'd0);
        check("reset_hs", 32'(o_h_sync), 32'd1);
        check("reset_frame", 32'(o_frame), 32'd0);
        #3;
        rst = 1'b0;

        // Load mode 1 (white) at the first frame start
        mode = 2'd1;
        vsync_pulse(3);
        check("first_frame", 32'(o_frame), 32'd1);

        // Latency and alignment: hsync falls and visible rises at x=0, y=0
        step(10, 0, 1'b0, 1'b1, 1'b1);
        step(11, 0, 1'b0, 1'b1, 1'b1);
        step(0, 0, 1'b1, 1'b0, 1'b1);
        check("lat1_hs", 32'(o_h_sync), 32'd1);
        check("lat1_rgb", 32'({o_r, o_g, o_b}), 32'd0);
        step(1, 0, 1'b1, 1'b0, 1'b1);
        check("lat2_hs", 32'(o_h_sync), 32'd0);
        check("lat2_rgb", 32'({o_r, o_g, o_b}), 32'h1FF);

        // Blanking at x=100
        step(100, 5, 1'b0, 1'b1, 1'b1);
        step(100, 5, 1'b1, 1'b1, 1'b1);
        check("blank_rgb", 32'({o_r, o_g, o_b}), 32'd0);
        step(101, 5, 1'b1, 1'b1, 1'b1);
        check("unblank_rgb", 32'({o_r, o_g, o_b}), 32'h1FF);

        // XOR pattern with frame = 8: (5^3) + 8/4 = 8
        while (m_frame < 7) vsync_pulse(2);
        mode = 2'd0;
        vsync_pulse(2);
        check("frame8", 32'(o_frame), 32'd8);
        step(5, 3, 1'b1, 1'b1, 1'b1);
        step(6, 3, 1'b1, 1'b1, 1'b1);
        check("xor_rgb", 32'({o_r, o_g, o_b}), 32'h008);

        // Mode deferral: a mid-frame change to checker does not take effect
        mode = 2'd2;
        step(32, 0, 1'b1, 1'b1, 1'b1);
        step(32, 0, 1'b1, 1'b1, 1'b1);
        check("defer_xor", 32'({o_r, o_g, o_b}), 32'(((32 ^ 0) + 2) % 512));
        vsync_pulse(2);
        step(32, 0, 1'b1, 1'b1, 1'b1);
        step(32, 32, 1'b1, 1'b1, 1'b1);
        check("checker_on", 32'({o_r, o_g, o_b}), 32'h1FF);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        check("checker_off", 32'({o_r, o_g, o_b}), 32'd0);

        // Frame wrap: preload 0xFFFF, then hold vsync active for two long lines
        dut.frame_cnt = 16'hFFFF;
        m_frame = 65535;
        step(0, 0, 1'b0, 1'b1, 1'b1);
        check("preload", 32'(o_frame), 32'hFFFF);
        fs_count = 0;
        vsync_pulse(1600);
        check("wrap_frame", 32'(o_frame), 32'd0);
        check("wrap_pulses", 32'(fs_count), 32'd1);

        // Random traffic checked against the model
        for (int i = 0; i < 2000; i++) begin
            mode = 2'($urandom_range(0, 3));
            step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) != 0));
        end

        // Reset asserted inside the vsync pulse, released while it is still active
        mode = 2'd1;
        vsync_pulse(2);
        step(7, 7, 1'b1, 1'b0, 1'b0);
        step(8, 7, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("async_rgb", 32'({o_r, o_g, o_b}), 32'd0);
        check("async_hs", 32'(o_h_sync), 32'd1);
        check("async_vs", 32'(o_v_sync), 32'd1);
        check("async_frame", 32'(o_frame), 32'd0);
        model_reset();
        step(9, 7, 1'b1, 1'b0, 1'b0);
        step(9, 7, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        fs_count = 0;
        for (int i = 0; i < 6; i++) step(0, 0, 1'b0, 1'b1, 1'b0);
        check("no_spurious_fs", 32'(fs_count), 32'd0);
        mode = 2'd3;
        vsync_pulse(2);
        check("post_reset_fs", 32'(fs_count), 32'd1);

`ifdef VGA_PIXEL_PIPE_COLOR_BARS_EN
        // Colour bar 5 at x=640
        step(640, 10, 1'b1, 1'b1, 1'b1);
        step(641, 10, 1'b1, 1'b1, 1'b1);
        check("bar5", 32'({o_r, o_g, o_b}), 32'h1C7);
`else
        // Mode 3 falls back to XOR; frame is 1 after the reset
        step(640, 10, 1'b1, 1'b1, 1'b1);
        step(641, 10, 1'b1, 1'b1, 1'b1);
        check("mode3_xor", 32'({o_r, o_g, o_b}), 32'(((640 ^ 10) + 0) % 512));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
